// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file write arbiter: controller states
// and the indices of the two write requesters.
package regfile_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant while advance is high; after a
// grant the pointer favours the requester that lost (or did not ask).
module rr_arbiter_2
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_reg;
    logic ptr_next;

    // A lone requester always wins; on a tie the pointer picks the winner.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = advance & valid[gi] & (~valid[1-gi] | (ptr_reg == 1'(gi)));
        end
    endgenerate

    always_comb begin
        ptr_next = ptr_reg;
        if (grant[REQ_ALU]) begin
            ptr_next = 1'(REQ_MEM);
        end else if (grant[REQ_MEM]) begin
            ptr_next = 1'(REQ_ALU);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU/MEM write requests onto a single registered register-array
// write port, with a zero-fill sweep of the whole array on clear_start.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int REGISTER_NUM   = 32,
    parameter int REGISTER_WIDTH = 32,
    parameter bit DISCARD_ZERO   = 1'b1,
    localparam int ADDR_W        = $clog2(REGISTER_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    input  logic [ADDR_W-1:0]         req0_address,
    input  logic [REGISTER_WIDTH-1:0] req0_data,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [ADDR_W-1:0]         req1_address,
    input  logic [REGISTER_WIDTH-1:0] req1_data,
    output logic                      req1_ready,
    input  logic                      hold,
    input  logic                      clear_start,
    output logic                      busy,
    output logic                      write_enable,
    output logic [ADDR_W-1:0]         write_reg_address,
    output logic [REGISTER_WIDTH-1:0] write_data
);

    state_t                    state_reg, state_next;
    logic [ADDR_W-1:0]         count_reg, count_next;
    logic                      we_reg, we_next;
    logic [ADDR_W-1:0]         addr_reg, addr_next;
    logic [REGISTER_WIDTH-1:0] data_reg, data_next;

    logic       arb_enable;
    logic [1:0] grant;

    // clear_start outranks requests, so arbitration only runs when it is low.
    assign arb_enable = (state_reg == IDLE) && !hold && !clear_start;

    rr_arbiter_2 u_rr_arbiter_2 (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .advance (arb_enable),
        .grant   (grant)
    );

    assign req0_ready        = grant[REQ_ALU] & rst;
    assign req1_ready        = grant[REQ_MEM] & rst;
    assign busy              = (state_reg == CLEAR);
    assign write_enable      = we_reg;
    assign write_reg_address = addr_reg;
    assign write_data        = data_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        data_next  = data_reg;
        unique case (state_reg)
            IDLE: begin
                if (!hold && clear_start) begin
                    state_next = CLEAR;
                    count_next = '0;
                end else if (|grant) begin
                    addr_next = grant[REQ_MEM] ? req1_address : req0_address;
                    data_next = grant[REQ_MEM] ? req1_data : req0_data;
                    // Writes to address 0 still handshake but never reach the array.
                    we_next   = !(DISCARD_ZERO && (addr_next == '0));
                end
            end
            CLEAR: begin
                if (!hold) begin
                    we_next   = 1'b1;
                    addr_next = count_reg;
                    data_next = '0;
                    if (count_reg == ADDR_W'(REGISTER_NUM - 1)) begin
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

endmodule
